// File: rtl/instruction_decode.sv
// Purpose : MIPS-style ID stage: IF/ID latch, 32x32 register file, control decode, load-use detect.
// Latency : instruction accepted into IF/ID at edge N is presented on ex_* after edge N+1.
// Backpressure: stall/flush freeze or kill IF/ID and ID/EX; hazard_stall asks fetch to hold for one cycle.
// Build option: define REGFILE_BYPASS_EN to make same-cycle writeback visible to register reads.
module instruction_decode #(
  parameter int PC_W     = 6,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc_plus_4,
  input  logic            if_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc_plus_4,
  output logic [31:0]     ex_rs_data,
  output logic [31:0]     ex_rt_data,
  output logic [31:0]     ex_imm,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic [PC_W-1:0] ex_branch_target
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Everything the EX stage sees, kept together so bubbles are a single '0.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc4;
    logic [31:0]     rs_data;
    logic [31:0]     rt_data;
    logic [31:0]     imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
    logic [PC_W-1:0] target;
  } idex_t;

  logic            ifid_valid;
  logic [31:0]     ifid_instr;
  logic [PC_W-1:0] ifid_pc4;

  logic [31:0] regs [NUM_REGS];

  idex_t idex_q;
  idex_t dec;

  logic [5:0]  id_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_imm;
  logic [31:0] rd_rs_data;
  logic [31:0] rd_rt_data;
  logic        uses_rt;
  logic        load_use;

  assign id_op    = ifid_instr[31:26];
  assign id_rs    = ifid_instr[25:21];
  assign id_rt    = ifid_instr[20:16];
  assign id_rd    = ifid_instr[15:11];
  assign id_funct = ifid_instr[5:0];
  assign id_imm   = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

  // Register file write port; r0 is hardwired so writes to it are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Register file read ports, with optional write-through of the current writeback.
  always_comb begin
    rd_rs_data = regs[id_rs];
    rd_rt_data = regs[id_rt];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == id_rs)) rd_rs_data = wb_data;
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == id_rt)) rd_rt_data = wb_data;
`endif
    if (id_rs == 5'd0) rd_rs_data = '0;
    if (id_rt == 5'd0) rd_rt_data = '0;
  end

  // Control decode of the IF/ID instruction; unknown encodings keep all controls low.
  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.pc4     = ifid_pc4;
    dec.rs_data = rd_rs_data;
    dec.rt_data = rd_rt_data;
    dec.imm     = id_imm;
    dec.rs      = id_rs;
    dec.rt      = id_rt;
    dec.rd      = (id_op == OP_RTYPE) ? id_rd : id_rt;
    // Branch offset is word-scaled; only the low PC_W bits of the sum survive.
    dec.target  = ifid_pc4 + {id_imm[PC_W-3:0], 2'b00};
    unique case (id_op)
      OP_RTYPE: begin
        unique case (id_funct)
          FN_ADD:  begin dec.alu_op = ALU_ADD; dec.reg_write = 1'b1; end
          FN_SUB:  begin dec.alu_op = ALU_SUB; dec.reg_write = 1'b1; end
          FN_AND:  begin dec.alu_op = ALU_AND; dec.reg_write = 1'b1; end
          FN_OR:   begin dec.alu_op = ALU_OR;  dec.reg_write = 1'b1; end
          FN_SLT:  begin dec.alu_op = ALU_SLT; dec.reg_write = 1'b1; end
          default: ;
        endcase
      end
      OP_LW: begin
        dec.alu_op     = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use detect: only R-type, sw and beq actually consume rt as a source.
  always_comb begin
    uses_rt  = (id_op == OP_RTYPE) || (id_op == OP_SW) || (id_op == OP_BEQ);
    load_use = ifid_valid && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
               ((idex_q.rd == id_rs) || (uses_rt && (idex_q.rd == id_rt)));
  end

  // Fetch only needs to hold when this stage would otherwise advance.
  assign hazard_stall = load_use && !flush && !stall;

  // IF/ID register: killed by flush, frozen by stall or a load-use hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end else if (stall || load_use) begin
      ifid_valid <= ifid_valid;
    end else begin
      ifid_valid <= if_valid;
      ifid_instr <= if_instr;
      ifid_pc4   <= if_pc_plus_4;
    end
  end

  // ID/EX register: bubble on flush, hazard or empty IF/ID; frozen by stall.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      idex_q <= '0;
    end else if (stall) begin
      idex_q <= idex_q;
    end else if (load_use || !ifid_valid) begin
      idex_q <= '0;
    end else begin
      idex_q <= dec;
    end
  end

  assign ex_valid         = idex_q.valid;
  assign ex_pc_plus_4     = idex_q.pc4;
  assign ex_rs_data       = idex_q.rs_data;
  assign ex_rt_data       = idex_q.rt_data;
  assign ex_imm           = idex_q.imm;
  assign ex_rs            = idex_q.rs;
  assign ex_rt            = idex_q.rt;
  assign ex_rd            = idex_q.rd;
  assign ex_alu_op        = idex_q.alu_op;
  assign ex_alu_src       = idex_q.alu_src;
  assign ex_mem_read      = idex_q.mem_read;
  assign ex_mem_write     = idex_q.mem_write;
  assign ex_reg_write     = idex_q.reg_write;
  assign ex_mem_to_reg    = idex_q.mem_to_reg;
  assign ex_branch        = idex_q.branch;
  assign ex_branch_target = idex_q.target;

endmodule
